// File: rtl/mobius_pkg.sv
// Shared types and helpers for the sequenced Mobius transform engine.
//   mobius_state_t : engine FSM state (IDLE, RUN, DONE)
//   clog2()        : ceiling log2, usable in constant expressions
//   stage_w()      : width of the stage counter for a given LOG2_N
package mobius_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mobius_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Stage counter must encode 0..LOG2_N-1; a one-stage engine still needs one bit.
  function automatic int stage_w(input int log2_n);
    return (clog2(log2_n) < 1) ? 1 : clog2(log2_n);
  endfunction

  localparam int DEFAULT_N      = 64;
  localparam int DEFAULT_LOG2_N = 6;

endpackage

// File: rtl/mobius_stage_var.sv
// One runtime-selectable Mobius butterfly stage over GF(2).
//   vec      [0:N-1]       : input vector, index 0 is the MSB
//   sel      [STAGE_W-1:0] : stage number 0..LOG2_N-1
//   vec_next [0:N-1]       : vec after applying stage 'sel'
// Stage s uses half = N >> (s+1): every index with the 'half' bit set
// absorbs (XOR) its partner index i-half. Purely combinational.
module mobius_stage_var
  import mobius_pkg::*;
#(
  parameter  int N       = DEFAULT_N,
  parameter  int LOG2_N  = DEFAULT_LOG2_N,
  localparam int STAGE_W = stage_w(LOG2_N)
) (
  input  logic [0:N-1]         vec,
  input  logic [STAGE_W-1:0]   sel,
  output logic [0:N-1]         vec_next
);

  logic [0:N-1] stage_out [LOG2_N];

  for (genvar s = 0; s < LOG2_N; s++) begin : g_stage
    localparam int HALF = N >> (s + 1);
    logic [0:N-1] v;

    for (genvar i = 0; i < N; i++) begin : g_bit
      if ((i & HALF) == 0) begin : g_keep
        assign v[i] = vec[i];
      end else begin : g_xor
        assign v[i] = vec[i] ^ vec[i - HALF];
      end
    end

    assign stage_out[s] = v;
  end

  // NOTE: the default assignment before the selection loop guarantees
  // vec_next is written on every path, so no latch is inferred.
  always_comb begin
    vec_next = stage_out[0];
    for (int k = 0; k < LOG2_N; k++) begin
      if (sel == STAGE_W'(k)) vec_next = stage_out[k];
    end
  end

endmodule

// File: rtl/mobius_seq.sv
// Folded Mobius transform engine: one butterfly stage per clock.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : producer handshake, in_data [0:N-1] (index 0 = MSB)
//   out_valid/out_ready : consumer handshake, out_data [0:N-1]
//   busy              : high while stages are being applied
//   stage_idx         : current stage number (debug)
// A vector accepted in cycle T is presented from cycle T+LOG2_N+1. In DONE
// a consumer handshake and a new accept may coincide, giving back-to-back
// operation with no idle cycle.
module mobius_seq
  import mobius_pkg::*;
#(
  parameter  int N       = DEFAULT_N,
  parameter  int LOG2_N  = DEFAULT_LOG2_N,
  localparam int STAGE_W = stage_w(LOG2_N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:N-1]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:N-1]       out_data,
  output logic               busy,
  output logic [STAGE_W-1:0] stage_idx
);

  if (N < 2 || (1 << LOG2_N) != N) begin : g_param_check
    $fatal(1, "mobius_seq: N must be a power of two >= 2 and equal 2**LOG2_N");
  end

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2_N - 1);

  mobius_state_t      state, state_next;
  logic [0:N-1]       work, work_next;
  logic [0:N-1]       stage_out;
  logic [STAGE_W-1:0] stage_next;
  logic               accept;

  mobius_stage_var #(
    .N      (N),
    .LOG2_N (LOG2_N)
  ) u_stage (
    .vec      (work),
    .sel      (stage_idx),
    .vec_next (stage_out)
  );

  // in_ready deliberately ignores in_valid so the producer never sees a
  // combinational loop through the handshake.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = work;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; the working register is reset too so
  // out_data reads as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      stage_idx <= '0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      stage_idx <= stage_next;
    end
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    stage_next = stage_idx;

    case (state)
      IDLE: begin
        if (accept) begin
          work_next  = in_data;
          stage_next = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        work_next = stage_out;
        if (stage_idx == LAST_STAGE) begin
          stage_next = '0;
          state_next = DONE;
        end else begin
          stage_next = stage_idx + STAGE_W'(1);
        end
      end
      DONE: begin
        if (accept) begin
          work_next  = in_data;
          stage_next = '0;
          state_next = RUN;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
